// File: rtl/fns_enc_07_seq.sv
// Sequential binary-to-Fibonacci (Zeckendorf) encoder: 6-bit value in, 7-bit codeword out, one weight per cycle.
// Optional range check enabled by defining FNS_ENC_RANGECHK_EN (flags datain > 33 with err=1, codeout=0).
module fns_enc_07_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] datain,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] codeout,
  output logic       err
);

  // Data width of the FNS family (FBLEN07); code width follows from the seven weights.
  localparam int FBLEN07 = 6;
  localparam logic [FBLEN07-1:0] MAX_LEGAL = 6'd33;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q, state_d;
  logic [FBLEN07-1:0] rem_q, rem_d;
  logic [2:0]         step_q, step_d;
  logic [6:0]         bits_q, bits_d;
  logic [6:0]         code_q, code_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [FBLEN07-1:0] weight_cur;

  function automatic logic [FBLEN07-1:0] fib_weight(input logic [2:0] s);
    case (s)
      3'd0:    fib_weight = 6'd1;
      3'd1:    fib_weight = 6'd2;
      3'd2:    fib_weight = 6'd3;
      3'd3:    fib_weight = 6'd5;
      3'd4:    fib_weight = 6'd8;
      3'd5:    fib_weight = 6'd13;
      3'd6:    fib_weight = 6'd21;
      default: fib_weight = 6'd0;
    endcase
  endfunction

`ifdef FNS_ENC_RANGECHK_EN
  logic err_q, err_d;
  logic oor_q, oor_d;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    step_d     = step_q;
    bits_d     = bits_q;
    code_d     = code_q;
    weight_cur = fib_weight(step_q);
`ifdef FNS_ENC_RANGECHK_EN
    err_d      = err_q;
    oor_d      = oor_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = CONV;
          rem_d   = datain;
          step_d  = 3'd6;
          bits_d  = 7'd0;
`ifdef FNS_ENC_RANGECHK_EN
          oor_d   = (datain > MAX_LEGAL);
`endif
        end
      end
      CONV: begin
        // Greedy step: subtract only when it fits, so the remainder never wraps.
        if (rem_q >= weight_cur) begin
          bits_d[step_q] = 1'b1;
          rem_d          = rem_q - weight_cur;
        end else begin
          bits_d[step_q] = 1'b0;
        end
        if (step_q == 3'd0) begin
          state_d = DONE;
          code_d  = bits_d;
`ifdef FNS_ENC_RANGECHK_EN
          if (oor_q) begin
            code_d = 7'd0;
            err_d  = 1'b1;
          end else begin
            err_d  = 1'b0;
          end
`endif
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      step_q      <= '0;
      bits_q      <= '0;
      code_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FNS_ENC_RANGECHK_EN
      err_q       <= 1'b0;
      oor_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      step_q      <= step_d;
      bits_q      <= bits_d;
      code_q      <= code_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef FNS_ENC_RANGECHK_EN
      err_q       <= err_d;
      oor_q       <= oor_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign codeout   = code_q;
`ifdef FNS_ENC_RANGECHK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fns_enc_07_seq.sv
// Bench for fns_enc_07_seq: directed words with literal expectations plus a cycle-level reference model
// checked every negedge. Honours FNS_ENC_RANGECHK_EN for the out-of-range expectation.
module tb_fns_enc_07_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] datain = 6'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] codeout;
  logic       err;

  int total = 0;
  int bad   = 0;
  int W [7] = '{1, 2, 3, 5, 8, 13, 21};

  // Reference model state (what the outputs must be after the next edge)
  int m_in_ready = 0, m_out_valid = 0, m_code = 0, m_err = 0;
  int m_cnt = 0, m_pcode = 0, m_perr = 0, m_fresh = 1;
  int exh_on = 0, exh_got = 0;

  fns_enc_07_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .datain(datain),
    .out_valid(out_valid), .out_ready(out_ready), .codeout(codeout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Greedy Fibonacci encoding from the largest weight downwards.
  function automatic void ref_enc(input int d, output int code, output int e);
    int r;
    r = d; code = 0; e = 0;
`ifdef FNS_ENC_RANGECHK_EN
    if (d > 33) begin
      e = 1;
      return;
    end
`endif
    for (int i = 6; i >= 0; i--) begin
      if (r >= W[i]) begin
        code = code | (1 << i);
        r = r - W[i];
      end
    end
  endfunction

  function automatic int fib_decode(input logic [6:0] c);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) if (c[i]) s += W[i];
    return s;
  endfunction

  // Compare process: checks every cycle, then advances the model over the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_codeout", int'(codeout), 0);
        chk("rst_err", int'(err), 0);
        m_in_ready = 0; m_out_valid = 0; m_code = 0; m_err = 0; m_cnt = 0; m_fresh = 1;
      end else begin
        chk("in_ready", int'(in_ready), m_in_ready);
        chk("out_valid", int'(out_valid), m_out_valid);
        chk("codeout", int'(codeout), m_code);
        chk("err", int'(err), m_err);
        if (exh_on != 0 && out_valid && out_ready) begin
          chk("exh_decode", fib_decode(codeout), exh_got);
          chk("exh_adjacent", int'(codeout & (codeout >> 1)), 0);
          exh_got++;
        end
        if (m_fresh != 0) begin
          m_in_ready = 1; m_fresh = 0;
        end else if (m_in_ready != 0 && in_valid) begin
          m_in_ready = 0; m_cnt = 7;
          ref_enc(int'(datain), m_pcode, m_perr);
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_out_valid = 1; m_code = m_pcode; m_err = m_perr;
          end
        end else if (m_out_valid != 0 && out_ready) begin
          m_out_valid = 0; m_in_ready = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [5:0] d, input int exp_code, input int exp_err, input int stall);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("wait_in_ready", int'(in_ready), 1);
    in_valid = 1'b1; datain = d; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    datain = 6'($urandom);
    k = 0;
    while (k < 20) begin
      step();
      k++;
      datain = 6'($urandom);
      if (out_valid) break;
    end
    chk("latency", k, 7);
    chk("word_code", int'(codeout), exp_code);
    chk("word_err", int'(err), exp_err);
    in_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_code", int'(codeout), exp_code);
      step();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("drop_out_valid", int'(out_valid), 0);
    chk("back_in_ready", int'(in_ready), 1);
    $display("word datain=%0d codeout=%b err=%0d stall=%0d", d, codeout, err, stall);
  endtask

  initial begin
    int k;
    int acc;
    logic [5:0] idx;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", int'(in_ready), 1);

    run_word(6'd0,  7'b0000000, 0, 0);
    run_word(6'd33, 7'b1010101, 0, 0);
    run_word(6'd20, 7'b0101010, 0, 5);
    run_word(6'd1,  7'b0000001, 0, 1);
`ifdef FNS_ENC_RANGECHK_EN
    run_word(6'd40, 7'b0000000, 1, 0);
`else
    run_word(6'd40, 7'b1101001, 0, 0);
`endif
    run_word(6'd12, 7'b0010101, 0, 0);

    // Abort mid-conversion: reset while step 3 is pending.
    run_word(6'd20, 7'b0101010, 0, 0);
    in_valid = 1'b1; datain = 6'd7;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("abort_codeout", int'(codeout), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    step();
    rst = 1'b0;
    step();
    $display("abort reset applied codeout=%b out_valid=%0d", codeout, out_valid);
    run_word(6'd33, 7'b1010101, 0, 0);

    // Exhaustive 0..33 back-to-back with random out_ready.
    exh_on = 1; exh_got = 0;
    idx = 6'd0; in_valid = 1'b1; datain = idx;
    k = 0;
    while (exh_got < 34 && k < 3000) begin
      @(negedge clk);
      acc = (in_valid && in_ready) ? 1 : 0;
      step();
      k++;
      if (acc != 0) begin
        idx = idx + 6'd1;
        if (idx == 6'd34) in_valid = 1'b0;
        else datain = idx;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("exh_count", exh_got, 34);
    $display("exhaustive words=%0d cycles=%0d", exh_got, k);
    exh_on = 0; out_ready = 1'b0; in_valid = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
